imem_access_arbiter: RTL and testbench
======================================

// Module: imem_access_arbiter
// PURPOSE
//  Shares the single-port instruction memory between two requesters: the fetch
//  unit (reads) and the program loader (writes that fill or patch code at runtime).
//  Grants one access per cycle and returns read data one cycle after the grant.
//  Guards against misaligned or out-of-range addresses. Sits between the datapath
//  fetch stage / loader and the memory array.
// PARAMETERS
//  DATA_WIDTH      32          width of instruction words
//  ADDR_WIDTH      32          width of byte addresses from requesters
//  DEPTH_WORDS     32          memory depth in words; valid word index 0..DEPTH_WORDS-1
//  MAX_LOAD_BURST  4           max consecutive loader grants while fetch is waiting
//  NOP_WORD        32'h00000013 word returned to fetch on a bad address (addi x0,x0,0)
// PORTS
//  clock        in   1           system clock, all state on posedge
//  reset        in   1           synchronous, active-low
//  fetch_req    in   1           fetch read request; held with fetch_addr until fetch_gnt
//  fetch_addr   in   ADDR_WIDTH  byte address (PC)
//  fetch_gnt    out  1           fetch request accepted this cycle
//  fetch_rvalid out  1           fetch_rdata valid; exactly 1 cycle after fetch_gnt
//  fetch_rdata  out  DATA_WIDTH  instruction word
//  load_req     in   1           loader write request; held with addr/wdata until load_gnt
//  load_addr    in   ADDR_WIDTH  byte address to write
//  load_wdata   in   DATA_WIDTH  word to write
//  load_gnt     out  1           loader request accepted this cycle
//  mem_en       out  1           memory access strobe
//  mem_we       out  1           1 = write, 0 = read
//  mem_addr     out  $clog2(DEPTH_WORDS)  word index (byte address >> 2)
//  mem_wdata    out  DATA_WIDTH  write data
//  mem_rdata    in   DATA_WIDTH  read data, valid the cycle after a read strobe
//  addr_err     out  1           1-cycle pulse: granted request had a bad address
// BEHAVIOUR
//  - Reset (reset==0 at posedge): load_streak=0, rd_pending=0, bad_pending=0,
//    fetch_rvalid=0, fetch_rdata=0, addr_err=0. While reset==0, fetch_gnt,
//    load_gnt, mem_en and mem_we are forced 0 (combinationally gated).
//  - Grants and mem_* are combinational from req inputs and state. Registered
//    state: load_streak, rd_pending, bad_pending, fetch_rvalid, fetch_rdata, addr_err.
//  - Arbitration (one grant per cycle, never both):
//    only one req -> grant it; both req -> loader wins unless
//    load_streak==MAX_LOAD_BURST, then fetch wins.
//  - load_streak: +1 on each load_gnt while fetch_req==1; cleared on fetch_gnt or
//    any cycle with fetch_req==0; saturates at MAX_LOAD_BURST.
//  - Bad address: addr[1:0]!=0 or (addr>>2)>=DEPTH_WORDS. The request is still
//    granted, but mem_en=0. Next cycle addr_err=1. A bad fetch returns
//    fetch_rvalid=1 with fetch_rdata=NOP_WORD. A bad load is dropped (no write).
//  - Good fetch grant: mem_en=1, mem_we=0, mem_addr=fetch_addr>>2; set rd_pending.
//    Next cycle fetch_rvalid=1 and fetch_rdata=mem_rdata (captured at that cycle's
//    posedge; held until the next fetch response).
//  - Good load grant: mem_en=1, mem_we=1, mem_addr=load_addr>>2, mem_wdata=load_wdata.
//  - Back-to-back fetch grants are allowed: one rvalid per grant, in order, every
//    cycle. Idle cycles: mem_en=0, mem_addr/mem_wdata=0.
//  - Load then fetch to the same word on the next cycle returns the new data
//    (memory write completes at the grant posedge).
//  - Reset asserted with a read in flight: the response is discarded and
//    fetch_rvalid stays 0 after reset releases.
// TESTING
//  1 fetch_req, addr 0x8 alone -> fetch_gnt same cycle, mem_addr=2, next cycle rvalid=1, rdata=mem[2].
//  2 fetch+load both held, MAX_LOAD_BURST=4 -> 4 load_gnt, then fetch_gnt, then loader again.
//  3 load 0x0000_0004 <= 0xDEADBEEF, then fetch 0x4 next cycle -> rdata=0xDEADBEEF.
//  4 fetch addr 0x6 and 0x80 (DEPTH 32) -> gnt, mem_en=0, next cycle rvalid=1, rdata=0x00000013, addr_err=1.
//  5 load to 0x81 -> load_gnt, mem_we=0, addr_err pulse, memory unchanged on readback.
//  6 reset low in the cycle after a fetch_gnt -> rvalid=0, all grants 0; after release, first fetch behaves as in 1.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: shares a single-port instruction memory between fetch reads and loader writes
module imem_access_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_WORDS = 32,
    parameter int MAX_LOAD_BURST = 4,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(32'h00000013)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           fetch_req,
    input  logic [ADDR_WIDTH-1:0]          fetch_addr,
    output logic                           fetch_gnt,
    output logic                           fetch_rvalid,
    output logic [DATA_WIDTH-1:0]          fetch_rdata,
    input  logic                           load_req,
    input  logic [ADDR_WIDTH-1:0]          load_addr,
    input  logic [DATA_WIDTH-1:0]          load_wdata,
    output logic                           load_gnt,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic                           addr_err
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int SW = $clog2(MAX_LOAD_BURST + 1);

    logic [SW-1:0]         load_streak;
    logic                  rd_pending;
    logic                  bad_pending;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  fetch_bad;
    logic                  load_bad;
    logic                  fetch_first;

    // Read data comes straight from the memory in the response cycle and is held afterwards.
    always_comb begin
        fetch_bad    = fetch_addr[1:0] != 2'b00 || (fetch_addr >> 2) >= ADDR_WIDTH'(DEPTH_WORDS);
        load_bad     = load_addr[1:0] != 2'b00 || (load_addr >> 2) >= ADDR_WIDTH'(DEPTH_WORDS);
        fetch_first  = fetch_req && (!load_req || load_streak == SW'(MAX_LOAD_BURST));
        fetch_gnt    = reset && fetch_first;
        load_gnt     = reset && load_req && !fetch_first;
        mem_en       = (fetch_gnt && !fetch_bad) || (load_gnt && !load_bad);
        mem_we       = load_gnt && !load_bad;
        mem_addr     = !mem_en ? '0 : mem_we ? load_addr[IW+1:2] : fetch_addr[IW+1:2];
        mem_wdata    = mem_we ? load_wdata : '0;
        fetch_rvalid = rd_pending || bad_pending;
        fetch_rdata  = rd_pending ? mem_rdata : bad_pending ? NOP_WORD : rdata_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            load_streak <= '0;
            rd_pending  <= 1'b0;
            bad_pending <= 1'b0;
            rdata_q     <= '0;
            addr_err    <= 1'b0;
        end else begin
            if (fetch_gnt || !fetch_req)
                load_streak <= '0;
            else if (load_gnt && load_streak != SW'(MAX_LOAD_BURST))
                load_streak <= load_streak + 1'b1;
            rd_pending  <= fetch_gnt && !fetch_bad;
            bad_pending <= fetch_gnt && fetch_bad;
            rdata_q     <= fetch_rdata;
            addr_err    <= (fetch_gnt && fetch_bad) || (load_gnt && load_bad);
        end
    end
endmodule

// File: tb/tb_imem_access_arbiter.sv
// tb_imem_access_arbiter: directed scenarios plus a randomized run against a behavioural model
module tb_imem_access_arbiter;
    localparam int DEPTH = 32;
    localparam int BURST = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_req = 1'b0, load_req = 1'b0;
    logic [31:0] fetch_addr = '0, load_addr = '0, load_wdata = '0;
    logic        fetch_gnt, fetch_rvalid, load_gnt, mem_en, mem_we, addr_err;
    logic [31:0] fetch_rdata, mem_wdata;
    logic [31:0] mem_rdata;
    logic [4:0]  mem_addr;

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    int n_checks = 0, n_fail = 0;

    always #5 clock = ~clock;

    imem_access_arbiter dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata), .load_gnt(load_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .addr_err(addr_err)
    );

    // Synchronous single-port memory: write lands at the strobe edge, read data appears after it.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    function automatic bit is_bad(logic [31:0] a);
        return (a % 4) != 0 || (a / 4) >= DEPTH;
    endfunction

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        fetch_req = 1; fetch_addr = 32'h8; load_req = 1; load_addr = 0; load_wdata = 0;
        @(negedge clock);
        n_checks++;
        if ({fetch_gnt, load_gnt, mem_en, mem_we} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_gating: got %b expected 0000", {fetch_gnt, load_gnt, mem_en, mem_we});
        end
        n_checks++;
        if ({fetch_rvalid, addr_err, fetch_rdata} !== 34'b0) begin
            n_fail++; $display("FAIL reset_regs: got %h expected 0", {fetch_rvalid, addr_err, fetch_rdata});
        end
        cyc();
        reset = 1; fetch_req = 0; load_req = 0;
        @(negedge clock);
        n_checks++;
        if ({mem_en, mem_addr, mem_wdata, fetch_rvalid} !== 39'b0) begin
            n_fail++; $display("FAIL idle_outputs: got %h expected 0", {mem_en, mem_addr, mem_wdata, fetch_rvalid});
        end
        cyc();
    endtask

    task automatic test_fill;
        for (int i = 0; i < DEPTH; i++) begin
            load_req = 1; load_addr = 32'(i * 4); load_wdata = $urandom;
            @(negedge clock);
            n_checks++;
            if ({load_gnt, fetch_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 5'(i), load_wdata}) begin
                n_fail++;
                $display("FAIL fill[%0d]: got %h expected %h", i,
                         {load_gnt, fetch_gnt, mem_en, mem_we, mem_addr, mem_wdata}, {4'b1011, 5'(i), load_wdata});
            end
            ref_mem[i] = load_wdata;
            cyc();
        end
        load_req = 0;
    endtask

    task automatic test_fetch_basic;
        fetch_req = 1; fetch_addr = 32'h8;
        @(negedge clock);
        n_checks++;
        if ({fetch_gnt, load_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 5'd2}) begin
            n_fail++; $display("FAIL fetch_grant: got %b expected 101000010", {fetch_gnt, load_gnt, mem_en, mem_we, mem_addr});
        end
        cyc();
        fetch_req = 0;
        @(negedge clock);
        n_checks++;
        if ({fetch_rvalid, fetch_rdata} !== {1'b1, ref_mem[2]}) begin
            n_fail++; $display("FAIL fetch_resp: got %h expected %h", {fetch_rvalid, fetch_rdata}, {1'b1, ref_mem[2]});
        end
        cyc();
        @(negedge clock);
        n_checks++;
        if ({fetch_rvalid, mem_en, fetch_rdata} !== {2'b00, ref_mem[2]}) begin
            n_fail++; $display("FAIL fetch_hold: got %h expected %h", {fetch_rvalid, mem_en, fetch_rdata}, {2'b00, ref_mem[2]});
        end
        cyc();
    endtask

    task automatic test_burst;
        logic prev_f = 0;
        logic exp_f;
        fetch_req = 1; fetch_addr = 32'h0; load_req = 1; load_addr = 32'h10; load_wdata = 32'hC0FFEE00;
        for (int i = 0; i < 10; i++) begin
            exp_f = (i % 5) == 4;
            @(negedge clock);
            n_checks++;
            if ({fetch_gnt, load_gnt} !== {exp_f, !exp_f}) begin
                n_fail++; $display("FAIL burst_grant[%0d]: got %b%b expected %b%b", i, fetch_gnt, load_gnt, exp_f, !exp_f);
            end
            n_checks++;
            if (fetch_rvalid !== prev_f) begin
                n_fail++; $display("FAIL burst_rvalid[%0d]: got %b expected %b", i, fetch_rvalid, prev_f);
            end
            if (prev_f) begin
                n_checks++;
                if (fetch_rdata !== ref_mem[0]) begin
                    n_fail++; $display("FAIL burst_rdata[%0d]: got %h expected %h", i, fetch_rdata, ref_mem[0]);
                end
            end
            if (!exp_f) ref_mem[4] = load_wdata;
            prev_f = exp_f;
            cyc();
            if (!exp_f) load_wdata = load_wdata + 1;
        end
        fetch_req = 0; load_req = 0;
        @(negedge clock);
        n_checks++;
        if ({fetch_rvalid, fetch_rdata} !== {1'b1, ref_mem[0]}) begin
            n_fail++; $display("FAIL burst_last_resp: got %h expected %h", {fetch_rvalid, fetch_rdata}, {1'b1, ref_mem[0]});
        end
        cyc();
    endtask

    task automatic test_load_then_fetch;
        load_req = 1; load_addr = 32'h4; load_wdata = 32'hDEADBEEF;
        @(negedge clock);
        n_checks++;
        if ({load_gnt, mem_we, mem_addr} !== {2'b11, 5'd1}) begin
            n_fail++; $display("FAIL ltf_load: got %b expected 1100001", {load_gnt, mem_we, mem_addr});
        end
        ref_mem[1] = 32'hDEADBEEF;
        cyc();
        load_req = 0; fetch_req = 1; fetch_addr = 32'h4;
        @(negedge clock);
        n_checks++;
        if ({fetch_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 5'd1}) begin
            n_fail++; $display("FAIL ltf_fetch: got %b expected 11000001", {fetch_gnt, mem_en, mem_we, mem_addr});
        end
        cyc();
        fetch_req = 0;
        @(negedge clock);
        n_checks++;
        if ({fetch_rvalid, fetch_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL ltf_rdata: got %h expected 1deadbeef", {fetch_rvalid, fetch_rdata});
        end
        cyc();
    endtask

    task automatic test_bad_fetch;
        logic [31:0] bad_addrs [2] = '{32'h6, 32'h80};
        foreach (bad_addrs[k]) begin
            fetch_req = 1; fetch_addr = bad_addrs[k];
            @(negedge clock);
            n_checks++;
            if ({fetch_gnt, mem_en, mem_we, addr_err} !== 4'b1000) begin
                n_fail++; $display("FAIL bad_fetch_gnt[%h]: got %b expected 1000", bad_addrs[k], {fetch_gnt, mem_en, mem_we, addr_err});
            end
            cyc();
            fetch_req = 0;
            @(negedge clock);
            n_checks++;
            if ({fetch_rvalid, addr_err, fetch_rdata} !== {2'b11, NOP}) begin
                n_fail++; $display("FAIL bad_fetch_resp[%h]: got %h expected %h", bad_addrs[k], {fetch_rvalid, addr_err, fetch_rdata}, {2'b11, NOP});
            end
            cyc();
            @(negedge clock);
            n_checks++;
            if ({fetch_rvalid, addr_err, fetch_rdata} !== {2'b00, NOP}) begin
                n_fail++; $display("FAIL bad_fetch_pulse[%h]: got %h expected %h", bad_addrs[k], {fetch_rvalid, addr_err, fetch_rdata}, {2'b00, NOP});
            end
            cyc();
        end
    endtask

    task automatic test_bad_load;
        load_req = 1; load_addr = 32'h81; load_wdata = 32'h12345678;
        @(negedge clock);
        n_checks++;
        if ({load_gnt, fetch_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1000, 37'b0}) begin
            n_fail++; $display("FAIL bad_load_gnt: got %h expected %h", {load_gnt, fetch_gnt, mem_en, mem_we, mem_addr, mem_wdata}, {4'b1000, 37'b0});
        end
        cyc();
        load_req = 0; fetch_req = 1; fetch_addr = 32'h0;
        @(negedge clock);
        n_checks++;
        if ({addr_err, fetch_gnt, mem_en} !== 3'b111) begin
            n_fail++; $display("FAIL bad_load_err: got %b expected 111", {addr_err, fetch_gnt, mem_en});
        end
        cyc();
        fetch_req = 0;
        @(negedge clock);
        n_checks++;
        if ({fetch_rvalid, addr_err, fetch_rdata} !== {2'b10, ref_mem[0]}) begin
            n_fail++; $display("FAIL bad_load_readback: got %h expected %h", {fetch_rvalid, addr_err, fetch_rdata}, {2'b10, ref_mem[0]});
        end
        cyc();
    endtask

    task automatic test_reset_inflight;
        fetch_req = 1; fetch_addr = 32'h8;
        @(negedge clock);
        n_checks++;
        if (fetch_gnt !== 1'b1) begin
            n_fail++; $display("FAIL inflight_gnt: got %b expected 1", fetch_gnt);
        end
        cyc();
        reset = 0; load_req = 1; load_addr = 32'h0;
        @(negedge clock);
        n_checks++;
        if ({fetch_gnt, load_gnt, mem_en, mem_we} !== 4'b0000) begin
            n_fail++; $display("FAIL inflight_gating: got %b expected 0000", {fetch_gnt, load_gnt, mem_en, mem_we});
        end
        cyc();
        reset = 1; fetch_req = 0; load_req = 0;
        @(negedge clock);
        n_checks++;
        if ({fetch_rvalid, addr_err, fetch_rdata} !== 34'b0) begin
            n_fail++; $display("FAIL inflight_discard: got %h expected 0", {fetch_rvalid, addr_err, fetch_rdata});
        end
        cyc();
        fetch_req = 1; fetch_addr = 32'h8;
        @(negedge clock);
        n_checks++;
        if ({fetch_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 5'd2}) begin
            n_fail++; $display("FAIL post_reset_fetch: got %b expected 11000010", {fetch_gnt, mem_en, mem_we, mem_addr});
        end
        cyc();
        fetch_req = 0;
        @(negedge clock);
        n_checks++;
        if ({fetch_rvalid, fetch_rdata} !== {1'b1, ref_mem[2]}) begin
            n_fail++; $display("FAIL post_reset_resp: got %h expected %h", {fetch_rvalid, fetch_rdata}, {1'b1, ref_mem[2]});
        end
        cyc();
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r < 8) return 32'($urandom_range(0, DEPTH - 1) * 4);
        if (r == 8) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        return ($urandom() | 32'h80) & ~32'h3;
    endfunction

    // Model works on whole transactions: who wins, what the memory sees, what fetch gets back.
    task automatic test_random;
        int streak = 0;
        bit f_done = 1, l_done = 1, exp_rv = 0, exp_err = 0;
        bit e_fg, e_lg, e_en, e_we, fb, lb;
        logic [31:0] exp_rd = 0, last = 0, e_wd;
        logic [4:0] e_addr;
        logic [74:0] got, want;
        reset = 0; fetch_req = 0; load_req = 0;
        cyc();
        reset = 1;
        for (int n = 0; n < 500; n++) begin
            if (f_done) begin fetch_req = $urandom_range(0, 3) != 0; fetch_addr = rand_addr(); end
            if (l_done) begin load_req = $urandom_range(0, 2) != 0; load_addr = rand_addr(); load_wdata = $urandom; end
            fb = is_bad(fetch_addr);
            lb = is_bad(load_addr);
            e_fg = fetch_req && (!load_req || streak >= BURST);
            e_lg = load_req && !e_fg;
            e_en = (e_fg && !fb) || (e_lg && !lb);
            e_we = e_lg && !lb;
            e_addr = !e_en ? 5'd0 : e_we ? 5'(load_addr / 4) : 5'(fetch_addr / 4);
            e_wd = e_we ? load_wdata : 32'd0;
            want = {e_fg, e_lg, e_en, e_we, e_addr, e_wd, exp_rv, exp_rv ? exp_rd : last, exp_err};
            @(negedge clock);
            got = {fetch_gnt, load_gnt, mem_en, mem_we, mem_addr, mem_wdata, fetch_rvalid, fetch_rdata, addr_err};
            n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL random[%0d]: got %h expected %h", n, got, want);
            end
            if (exp_rv) last = exp_rd;
            exp_rv = e_fg;
            if (e_fg) exp_rd = fb ? NOP : ref_mem[fetch_addr / 4];
            exp_err = (e_fg && fb) || (e_lg && lb);
            if (e_we) ref_mem[load_addr / 4] = load_wdata;
            if (e_fg || !fetch_req) streak = 0;
            else if (e_lg && streak < BURST) streak++;
            f_done = !fetch_req || e_fg;
            l_done = !load_req || e_lg;
            cyc();
        end
        fetch_req = 0; load_req = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_fetch_basic();
        test_burst();
        test_load_then_fetch();
        test_bad_fetch();
        test_bad_load();
        test_reset_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
